// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the frame-buffer read arbiter.
// Arbiter state and in-flight tag encodings live here so the top, the tag
// pipeline and any checker agree on one definition.
package vram_arb_pkg;

  localparam int VRAM_ADDR_W = 18;
  localparam int VRAM_DATA_W = 24;

  // Issue slot currently presented on mem_addr
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_V  = 2'd1,
    ISSUE_A  = 2'd2,
    ISSUE_AF = 2'd3
  } arb_state_t;

  // Owner of a read travelling through the memory latency
  typedef enum logic [1:0] {
    NONE = 2'd0,
    VID  = 2'd1,
    AUX  = 2'd2
  } rd_tag_t;

  // Owner tag that an issue slot pushes into the tag pipeline
  function automatic rd_tag_t slot_tag(arb_state_t s);
    case (s)
      ISSUE_V:           return VID;
      ISSUE_A, ISSUE_AF: return AUX;
      default:           return NONE;
    endcase
  endfunction

endpackage

// File: rtl/vram_read_arbiter_if.sv
// Bundle of requester, memory and status signals around vram_read_arbiter.
//
// Handshake semantics: video_req is fire-and-forget (no ready; a sampled
// request is either issued or reported through video_drop). aux_req is a
// valid-style request: it stays high with aux_addr stable until aux_gnt is
// seen; the cycle that shows aux_gnt is a dead cycle for aux_req, after which
// a still-high aux_req is a new request. Withdrawing aux_req before the grant
// is allowed. rvalid strobes carry no back-pressure.
interface vram_read_arbiter_if
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) ();

  logic              video_req;
  logic [ADDR_W-1:0] video_addr;
  logic              video_rvalid;
  logic [DATA_W-1:0] video_rdata;
  logic              video_drop;
  logic              aux_req;
  logic [ADDR_W-1:0] aux_addr;
  logic              aux_gnt;
  logic              aux_rvalid;
  logic [DATA_W-1:0] aux_rdata;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              underrun;
  logic              underrun_clr;
  arb_state_t        dbg_state;

  modport slave (
    input  video_req, video_addr, aux_req, aux_addr, mem_rdata, underrun_clr,
    output video_rvalid, video_rdata, video_drop, aux_gnt, aux_rvalid,
           aux_rdata, mem_re, mem_addr, underrun, dbg_state
  );

  modport master (
    output video_req, video_addr, aux_req, aux_addr, mem_rdata, underrun_clr,
    input  video_rvalid, video_rdata, video_drop, aux_gnt, aux_rvalid,
           aux_rdata, mem_re, mem_addr, underrun, dbg_state
  );

endinterface

// File: rtl/vram_read_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: shift register of read-owner tags that tracks reads through
// the memory latency. DEPTH stages; the oldest tag is presented on tag_out.
module rd_tag_pipe
  import vram_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t stages [DEPTH];

  // Shift tags one stage per cycle; reset discards every in-flight owner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= NONE;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/vram_read_arbiter.sv
// vram_read_arbiter: shares frame-buffer read port B between video scan-out
// and an auxiliary reader. Video has priority; one read per cycle; returned
// data is routed to its owner by a tag pipeline of RD_LAT+1 stages.
// Optional feature macro: VRAM_ARB_STARVE_GUARD_EN enables the aux starvation
// guard (wait counter, forced ISSUE_AF grant, video_drop and underrun).
module vram_read_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W   = VRAM_ADDR_W,
  parameter int DATA_W   = VRAM_DATA_W,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 8
) (
  input logic               clk,
  input logic               rst,
  vram_read_arbiter_if.slave bus
);

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  arb_state_t        state, state_nxt;
  logic              aux_live;
  logic              mem_re_c, aux_gnt_c, video_drop_c;
  logic              underrun_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              video_rvalid_q, aux_rvalid_q;
  logic [DATA_W-1:0] video_rdata_q, aux_rdata_q;
  rd_tag_t           tag_out;

  // The grant cycle hides aux_req so the requester can retire or replace it
  assign aux_live = bus.aux_req && !aux_gnt_c;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  logic [7:0] wait_cnt;
  logic       vid_at_dec;
`endif

  // State register: the issue slot now on mem_addr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next slot: forced aux beats video, video beats ordinary aux
  always_comb begin
    state_nxt = IDLE;
    if (bus.video_req) state_nxt = ISSUE_V;
    else if (aux_live) state_nxt = ISSUE_A;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    if (aux_live && (wait_cnt == WAIT_LIM)) state_nxt = ISSUE_AF;
`endif
  end

  // Outputs decoded from the current slot
  always_comb begin
    mem_re_c     = (state != IDLE);
    aux_gnt_c    = (state == ISSUE_A) || (state == ISSUE_AF);
    video_drop_c = 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    video_drop_c = (state == ISSUE_AF) && vid_at_dec;
`endif
  end

`ifdef VRAM_ARB_STARVE_GUARD_EN
  // Count refused aux cycles; any grant or withdrawal restarts the wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= 8'd0;
      vid_at_dec <= 1'b0;
    end else begin
      vid_at_dec <= bus.video_req;
      if (!bus.aux_req || state_nxt == ISSUE_A || state_nxt == ISSUE_AF)
        wait_cnt <= 8'd0;
      else if (aux_live && wait_cnt != WAIT_LIM)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Sticky underrun flag; a drop in the clear cycle keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   underrun_q <= 1'b0;
    else if (video_drop_c)     underrun_q <= 1'b1;
    else if (bus.underrun_clr) underrun_q <= 1'b0;
  end
`else
  logic       unused_clr;
  logic [7:0] unused_wait_lim;
  assign unused_clr      = bus.underrun_clr;
  assign unused_wait_lim = WAIT_LIM;
  assign underrun_q      = 1'b0;
`endif

  // Registered address for port B; held while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       mem_addr_q <= '0;
    else if (state_nxt == ISSUE_V) mem_addr_q <= bus.video_addr;
    else if (state_nxt != IDLE)    mem_addr_q <= bus.aux_addr;
  end

  rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (slot_tag(state_nxt)),
    .tag_out (tag_out)
  );

  // Capture returning data for the owner named by the popped tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      video_rvalid_q <= 1'b0;
      aux_rvalid_q   <= 1'b0;
      video_rdata_q  <= '0;
      aux_rdata_q    <= '0;
    end else begin
      video_rvalid_q <= 1'b0;
      aux_rvalid_q   <= 1'b0;
      case (tag_out)
        VID: begin
          video_rvalid_q <= 1'b1;
          video_rdata_q  <= bus.mem_rdata;
        end
        AUX: begin
          aux_rvalid_q <= 1'b1;
          aux_rdata_q  <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_re       = mem_re_c;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.aux_gnt      = aux_gnt_c;
  assign bus.video_drop   = video_drop_c;
  assign bus.underrun     = underrun_q;
  assign bus.video_rvalid = video_rvalid_q;
  assign bus.video_rdata  = video_rdata_q;
  assign bus.aux_rvalid   = aux_rvalid_q;
  assign bus.aux_rdata    = aux_rdata_q;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_vram_read_arbiter.sv
// Bench for vram_read_arbiter (RD_LAT=2, MAX_WAIT=8). Works with or without
// VRAM_ARB_STARVE_GUARD_EN; the reference model follows the same macro.
module tb_vram_read_arbiter;
  import vram_arb_pkg::*;

  localparam int AW = 18;
  localparam int DW = 24;
  localparam int RL = 2;
  localparam int MW = 8;
  localparam int VW = 1 + DW + 1 + DW + 1 + 1 + 1 + AW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vram_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- memory model: data = address, RL cycles late ----------------
  logic [AW-1:0] hist [RL];
  always @(posedge clk) begin
    hist[0] <= bus.mem_addr;
    for (int i = 1; i < RL; i++) hist[i] <= hist[i-1];
  end
  assign bus.mem_rdata = DW'(hist[RL-1]);

  // ---------------- reference model ----------------
  // Transaction level: decide the owner of each edge from the arbitration
  // rules, then deliver the read RL+1 edges later from a queue.
  typedef struct {
    int            due;
    int            owner;
    logic [AW-1:0] addr;
  } pend_t;
  pend_t pend_q[$];

  int            cyc = 0;
  int            wait_m = 0;
  logic          m_gnt = 0, m_drop = 0, m_re = 0, m_vrv = 0, m_arv = 0, m_un = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_vdata = '0, m_adata = '0;
  bit            live, forced, prev_drop;
  int            owner;
  pend_t         p;

  always @(posedge clk) begin
    if (rst) begin
      pend_q.delete();
      wait_m = 0;
      {m_gnt, m_drop, m_re, m_vrv, m_arv, m_un} = '0;
      m_addr = '0; m_vdata = '0; m_adata = '0;
    end else begin
      prev_drop = m_drop;
      live   = bus.aux_req && !m_gnt;
      forced = 1'b0;
      owner  = 0;
      if (bus.video_req) owner = 1;
      else if (live)     owner = 2;
`ifdef VRAM_ARB_STARVE_GUARD_EN
      if (live && wait_m == MW) begin owner = 2; forced = 1'b1; end
      if (prev_drop) m_un = 1'b1;
      else if (bus.underrun_clr) m_un = 1'b0;
`endif
      m_drop = forced && bus.video_req;
      if (!bus.aux_req || owner == 2) wait_m = 0;
      else if (live && wait_m < MW) wait_m++;
      m_gnt = (owner == 2);
      m_re  = (owner != 0);
      if (owner == 1) m_addr = bus.video_addr;
      if (owner == 2) m_addr = bus.aux_addr;
      m_vrv = 1'b0;
      m_arv = 1'b0;
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        p = pend_q.pop_front();
        if (p.owner == 1) begin m_vrv = 1'b1; m_vdata = DW'(p.addr); end
        else begin m_arv = 1'b1; m_adata = DW'(p.addr); end
      end
      if (owner != 0) pend_q.push_back('{cyc + RL + 1, owner, m_addr});
    end
    cyc++;
  end

  logic [VW-1:0] exp_vec, obs_vec;
  assign exp_vec = {m_vrv, m_vdata, m_arv, m_adata, m_gnt, m_drop, m_re, m_addr, m_un};
  assign obs_vec = {bus.video_rvalid, bus.video_rdata, bus.aux_rvalid, bus.aux_rdata,
                    bus.aux_gnt, bus.video_drop, bus.mem_re, bus.mem_addr, bus.underrun};

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_errors = 0;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [AW-1:0] va, input logic a,
                       input logic [AW-1:0] aa, input logic c);
    bus.video_req    = v;
    bus.video_addr   = va;
    bus.aux_req      = a;
    bus.aux_addr     = aa;
    bus.underrun_clr = c;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(0, '0, 0, '0, 0);
    tick(); tick();
    n_checks++;
    if (obs_vec !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h expected 0", obs_vec);
    end
    n_checks++;
    if (bus.dbg_state !== IDLE) begin
      n_errors++;
      $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, IDLE);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (obs_vec !== exp_vec) begin
      n_errors++;
      $display("FAIL reset_idle: got %h expected %h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_reset_drain();
    for (int c = 0; c < 3; c++) begin
      drive(1, AW'(18'h00100 + c), 0, '0, 0);
      tick();
    end
    drive(0, '0, 0, '0, 0);
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs_vec !== '0) begin
      n_errors++;
      $display("FAIL drain_async_clear: got %h expected 0", obs_vec);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (bus.video_rvalid !== 1'b0 || obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL drain_no_rvalid c=%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_video_stream();
    int nxt = 0;
    for (int c = 0; c < 16; c++) begin
      drive(c < 10, AW'(c), 0, '0, 0);
      tick();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL stream_vec c=%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (bus.video_rvalid === 1'b1) begin
        n_checks++;
        if (bus.video_rdata !== DW'(nxt) || c != nxt + 3) begin
          n_errors++;
          $display("FAIL stream_data c=%0d: got data %h expected %h at c=%0d",
                   c, bus.video_rdata, nxt, nxt + 3);
        end
        nxt++;
      end
    end
    n_checks++;
    if (nxt != 10) begin
      n_errors++;
      $display("FAIL stream_count: got %0d expected 10", nxt);
    end
  endtask

  task automatic test_idle_aux();
    logic held = 1'b1;
    for (int c = 0; c < 6; c++) begin
      drive(0, '0, held, 18'h3FFFF, 0);
      tick();
      if (bus.aux_gnt === 1'b1) held = 1'b0;
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL idle_aux_vec c=%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (c == 0) begin
        n_checks++;
        if (bus.aux_gnt !== 1'b1 || bus.mem_addr !== 18'h3FFFF) begin
          n_errors++;
          $display("FAIL idle_aux_gnt: got gnt=%b addr=%h expected gnt=1 addr=3ffff",
                   bus.aux_gnt, bus.mem_addr);
        end
      end
      if (c == 3) begin
        n_checks++;
        if (bus.aux_rvalid !== 1'b1 || bus.aux_rdata !== 24'h03FFFF) begin
          n_errors++;
          $display("FAIL idle_aux_data: got rv=%b data=%h expected rv=1 data=03ffff",
                   bus.aux_rvalid, bus.aux_rdata);
        end
      end
    end
  endtask

  task automatic test_contention();
    int gnt_at = -1;
    int drop2_at = -1;
    logic clr = 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    for (int c = 0; c < 24; c++) begin
      drive(1, AW'($urandom), 1, 18'h2A5A5, clr);
      clr = 1'b0;
      tick();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL cont_vec c=%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (bus.aux_gnt === 1'b1 && gnt_at < 0) begin
        gnt_at = c;
        n_checks++;
        if (c != 8 || bus.video_drop !== 1'b1) begin
          n_errors++;
          $display("FAIL cont_forced_gnt: got c=%0d drop=%b expected c=8 drop=1",
                   c, bus.video_drop);
        end
      end else if (bus.video_drop === 1'b1) begin
        drop2_at = c;
        clr = 1'b1;
      end
      if (c == 9 || c == drop2_at + 1) begin
        n_checks++;
        if (bus.underrun !== 1'b1) begin
          n_errors++;
          $display("FAIL cont_underrun c=%0d: got %b expected 1", c, bus.underrun);
        end
      end
    end
    n_checks++;
    if (drop2_at != 18) begin
      n_errors++;
      $display("FAIL cont_second_drop: got c=%0d expected 18", drop2_at);
    end
    drive(0, '0, 0, '0, 1);
    tick();
    tick();
    n_checks++;
    if (bus.underrun !== 1'b0) begin
      n_errors++;
      $display("FAIL cont_underrun_clr: got %b expected 0", bus.underrun);
    end
`else
    for (int c = 0; c < 16; c++) begin
      drive(c < 12, AW'($urandom), gnt_at < 0, 18'h2A5A5, 0);
      tick();
      n_checks++;
      if (obs_vec !== exp_vec || bus.video_drop !== 1'b0) begin
        n_errors++;
        $display("FAIL cont_vec c=%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (bus.aux_gnt === 1'b1 && gnt_at < 0) gnt_at = c;
    end
    n_checks++;
    if (gnt_at != 12) begin
      n_errors++;
      $display("FAIL cont_strict_gnt: got c=%0d expected 12", gnt_at);
    end
`endif
    drive(0, '0, 0, '0, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL cont_drain c=%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   n_gnt = 0;
    logic prev = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(0, '0, 1, AW'(18'h01000 + c), 0);
      tick();
      n_checks++;
      if (obs_vec !== exp_vec || (prev === 1'b1 && bus.aux_gnt === 1'b1)) begin
        n_errors++;
        $display("FAIL b2b_vec c=%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
      if (bus.aux_gnt === 1'b1) n_gnt++;
      prev = bus.aux_gnt;
    end
    n_checks++;
    if (n_gnt != 6) begin
      n_errors++;
      $display("FAIL b2b_gnt_count: got %0d expected 6", n_gnt);
    end
    drive(0, '0, 0, '0, 0);
    for (int c = 0; c < 5; c++) tick();
  endtask

  task automatic test_random();
    logic          areq = 1'b0;
    logic [AW-1:0] aaddr = '0;
    for (int c = 0; c < 400; c++) begin
      if (areq && bus.aux_gnt === 1'b1) begin
        areq = ($urandom_range(0, 1) == 1);
        aaddr = AW'($urandom);
      end else if (!areq && $urandom_range(0, 3) == 0) begin
        areq = 1'b1;
        aaddr = AW'($urandom);
      end else if (areq && $urandom_range(0, 19) == 0) begin
        areq = 1'b0;
      end
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 9) < 7, AW'($urandom), areq, aaddr,
            $urandom_range(0, 9) == 0);
      tick();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL random_vec c=%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
    end
    rst = 1'b0;
    drive(0, '0, 0, '0, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_errors++;
        $display("FAIL random_drain c=%0d: got %h expected %h", c, obs_vec, exp_vec);
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_reset_drain();
    test_video_stream();
    test_idle_aux();
    test_contention();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
